// File: rtl/cpl_enqueue_client.sv
// cpl_enqueue_client
// Takes one completion record at a time, reserves a slot in the target
// completion queue through the queue manager, writes the record to the
// returned slot address, waits for the write to finish, then commits the
// slot. If the queue manager refuses the slot (full, error, or a stale tag),
// the completion is dropped and counted.
// Every valid/ready output is a flop, so no ready input can reach a valid
// output combinationally.

module cpl_enqueue_client #(
  parameter int QUEUE_INDEX_WIDTH = 5,
  parameter int REQ_TAG_WIDTH     = 8,
  parameter int OP_TAG_WIDTH      = 6,
  parameter int ADDR_WIDTH        = 64,
  parameter int CPL_WIDTH         = 128
) (
  input  logic                         clk,
  input  logic                         rst,

  // completion input
  input  logic [QUEUE_INDEX_WIDTH-1:0] s_cpl_queue,
  input  logic [CPL_WIDTH-1:0]         s_cpl_data,
  input  logic                         s_cpl_valid,
  output logic                         s_cpl_ready,

  // enqueue request to queue manager
  output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_enqueue_req_queue,
  output logic [REQ_TAG_WIDTH-1:0]     m_axis_enqueue_req_tag,
  output logic                         m_axis_enqueue_req_valid,
  input  logic                         m_axis_enqueue_req_ready,

  // enqueue response from queue manager
  input  logic [ADDR_WIDTH-1:0]        s_axis_enqueue_resp_addr,
  input  logic [REQ_TAG_WIDTH-1:0]     s_axis_enqueue_resp_tag,
  input  logic [OP_TAG_WIDTH-1:0]      s_axis_enqueue_resp_op_tag,
  input  logic                         s_axis_enqueue_resp_full,
  input  logic                         s_axis_enqueue_resp_error,
  input  logic                         s_axis_enqueue_resp_valid,
  output logic                         s_axis_enqueue_resp_ready,

  // enqueue commit to queue manager
  output logic [OP_TAG_WIDTH-1:0]      m_axis_enqueue_commit_op_tag,
  output logic                         m_axis_enqueue_commit_valid,
  input  logic                         m_axis_enqueue_commit_ready,

  // record write
  output logic [ADDR_WIDTH-1:0]        m_wr_addr,
  output logic [CPL_WIDTH-1:0]         m_wr_data,
  output logic                         m_wr_valid,
  input  logic                         m_wr_ready,
  input  logic                         s_wr_done,

  // status
  output logic [15:0]                  drop_count,
  output logic                         busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_WRITE,
    ST_WAIT_DONE,
    ST_COMMIT
  } state_t;

  state_t                     state;
  logic [REQ_TAG_WIDTH-1:0]   tag_cnt;
  logic [15:0]                drop_cnt;

  logic cpl_xfer, req_xfer, resp_xfer, wr_xfer, commit_xfer;
  logic resp_ok;

  assign cpl_xfer    = s_cpl_valid & s_cpl_ready;
  assign req_xfer    = m_axis_enqueue_req_valid & m_axis_enqueue_req_ready;
  assign resp_xfer   = s_axis_enqueue_resp_valid & s_axis_enqueue_resp_ready;
  assign wr_xfer     = m_wr_valid & m_wr_ready;
  assign commit_xfer = m_axis_enqueue_commit_valid & m_axis_enqueue_commit_ready;

  // A slot is usable only if the queue accepted it and the response echoes
  // the tag of the request that is outstanding (held on the req_tag output).
  assign resp_ok = ~s_axis_enqueue_resp_full & ~s_axis_enqueue_resp_error &
                   (s_axis_enqueue_resp_tag == m_axis_enqueue_req_tag);

  assign busy       = (state != ST_IDLE);
  assign drop_count = drop_cnt;

  // Single-completion FSM; all handshake and payload outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                        <= ST_IDLE;
      tag_cnt                      <= '0;
      drop_cnt                     <= '0;
      s_cpl_ready                  <= 1'b0;
      m_axis_enqueue_req_queue     <= '0;
      m_axis_enqueue_req_tag       <= '0;
      m_axis_enqueue_req_valid     <= 1'b0;
      s_axis_enqueue_resp_ready    <= 1'b0;
      m_axis_enqueue_commit_op_tag <= '0;
      m_axis_enqueue_commit_valid  <= 1'b0;
      m_wr_addr                    <= '0;
      m_wr_data                    <= '0;
      m_wr_valid                   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpl_xfer) begin
            s_cpl_ready              <= 1'b0;
            m_axis_enqueue_req_queue <= s_cpl_queue;
            m_axis_enqueue_req_tag   <= tag_cnt;
            m_wr_data                <= s_cpl_data;
            m_axis_enqueue_req_valid <= 1'b1;
            state                    <= ST_REQ;
          end else begin
            // also covers the first edge after reset release
            s_cpl_ready <= 1'b1;
          end
        end

        ST_REQ: begin
          if (req_xfer) begin
            m_axis_enqueue_req_valid  <= 1'b0;
            tag_cnt                   <= tag_cnt + 1'b1;
            s_axis_enqueue_resp_ready <= 1'b1;
            state                     <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (resp_xfer) begin
            s_axis_enqueue_resp_ready <= 1'b0;
            if (resp_ok) begin
              m_wr_addr                    <= s_axis_enqueue_resp_addr;
              m_axis_enqueue_commit_op_tag <= s_axis_enqueue_resp_op_tag;
              m_wr_valid                   <= 1'b1;
              state                        <= ST_WRITE;
            end else begin
              // refused slot: count once, no write, no commit
              if (drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
              s_cpl_ready <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end

        ST_WRITE: begin
          if (wr_xfer) begin
            m_wr_valid <= 1'b0;
            state      <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          // write-done pulses outside this state are not looked at
          if (s_wr_done) begin
            m_axis_enqueue_commit_valid <= 1'b1;
            state                       <= ST_COMMIT;
          end
        end

        ST_COMMIT: begin
          if (commit_xfer) begin
            m_axis_enqueue_commit_valid <= 1'b0;
            s_cpl_ready                 <= 1'b1;
            state                       <= ST_IDLE;
          end
        end

        default: begin
          s_cpl_ready                 <= 1'b0;
          m_axis_enqueue_req_valid    <= 1'b0;
          s_axis_enqueue_resp_ready   <= 1'b0;
          m_wr_valid                  <= 1'b0;
          m_axis_enqueue_commit_valid <= 1'b0;
          state                       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpl_enqueue_client.sv
// Directed bench for cpl_enqueue_client: normal flow, refused slots,
// tag mismatch, backpressure, reset mid-flight, tag wrap and drop saturation.

module tb_cpl_enqueue_client;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   s_cpl_queue;
  logic [127:0] s_cpl_data;
  logic         s_cpl_valid;
  logic         s_cpl_ready;
  logic [4:0]   req_queue;
  logic [7:0]   req_tag;
  logic         req_valid;
  logic         req_ready;
  logic [63:0]  resp_addr;
  logic [7:0]   resp_tag;
  logic [5:0]   resp_op_tag;
  logic         resp_full;
  logic         resp_error;
  logic         resp_valid;
  logic         resp_ready;
  logic [5:0]   commit_op_tag;
  logic         commit_valid;
  logic         commit_ready;
  logic [63:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic         wr_done;
  logic [15:0]  drop_count;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int rq_cnt = 0;
  int wr_cnt = 0;
  int cm_cnt = 0;

  always #5 clk = ~clk;

  cpl_enqueue_client dut (
    .clk                          (clk),
    .rst                          (rst),
    .s_cpl_queue                  (s_cpl_queue),
    .s_cpl_data                   (s_cpl_data),
    .s_cpl_valid                  (s_cpl_valid),
    .s_cpl_ready                  (s_cpl_ready),
    .m_axis_enqueue_req_queue     (req_queue),
    .m_axis_enqueue_req_tag       (req_tag),
    .m_axis_enqueue_req_valid     (req_valid),
    .m_axis_enqueue_req_ready     (req_ready),
    .s_axis_enqueue_resp_addr     (resp_addr),
    .s_axis_enqueue_resp_tag      (resp_tag),
    .s_axis_enqueue_resp_op_tag   (resp_op_tag),
    .s_axis_enqueue_resp_full     (resp_full),
    .s_axis_enqueue_resp_error    (resp_error),
    .s_axis_enqueue_resp_valid    (resp_valid),
    .s_axis_enqueue_resp_ready    (resp_ready),
    .m_axis_enqueue_commit_op_tag (commit_op_tag),
    .m_axis_enqueue_commit_valid  (commit_valid),
    .m_axis_enqueue_commit_ready  (commit_ready),
    .m_wr_addr                    (wr_addr),
    .m_wr_data                    (wr_data),
    .m_wr_valid                   (wr_valid),
    .m_wr_ready                   (wr_ready),
    .s_wr_done                    (wr_done),
    .drop_count                   (drop_count),
    .busy                         (busy)
  );

  // transfer counters, to catch duplicated or missing handshakes
  always @(posedge clk) begin
    if (req_valid && req_ready)       rq_cnt++;
    if (wr_valid && wr_ready)         wr_cnt++;
    if (commit_valid && commit_ready) cm_cnt++;
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // offer a completion and return right after the edge it is taken on
  task automatic send_cpl(input logic [4:0] q, input logic [127:0] d);
    int n;
    n = 0;
    s_cpl_queue = q;
    s_cpl_data  = d;
    s_cpl_valid = 1'b1;
    while (!s_cpl_ready && n < 20) begin
      tick;
      n++;
    end
    if (!s_cpl_ready) chk("cpl_ready_timeout", 0, 1);
    tick;
    s_cpl_valid = 1'b0;
  endtask

  // present one response beat while the block is in RESP
  task automatic send_resp(input logic [63:0] a, input logic [7:0] t, input logic [5:0] op,
                           input logic f, input logic e);
    chk("resp_ready", resp_ready, 1);
    resp_addr   = a;
    resp_tag    = t;
    resp_op_tag = op;
    resp_full   = f;
    resp_error  = e;
    resp_valid  = 1'b1;
    tick;
    resp_valid  = 1'b0;
    resp_full   = 1'b0;
    resp_error  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, cycles exceeded");
    $fatal(1);
  end

  initial begin
    int b;
    logic [127:0] da5;
    logic [7:0]   et;
    da5 = {16{8'hA5}};
    rst = 1'b1;
    s_cpl_queue = '0; s_cpl_data = '0; s_cpl_valid = 1'b0;
    req_ready = 1'b1; wr_ready = 1'b1; commit_ready = 1'b1;
    resp_addr = '0; resp_tag = '0; resp_op_tag = '0;
    resp_full = 1'b0; resp_error = 1'b0; resp_valid = 1'b0;
    wr_done = 1'b0;

    // reset state
    #12;
    chk("rst_cpl_ready", s_cpl_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_drop", drop_count, 0);
    tick;
    rst = 1'b0;
    chk("ready_before_edge", s_cpl_ready, 0);
    tick;
    chk("ready_after_rst", s_cpl_ready, 1);

    // normal completion
    send_cpl(5'd3, da5);
    chk("n_req_valid", req_valid, 1);
    chk("n_req_queue", req_queue, 3);
    chk("n_req_tag", req_tag, 0);
    chk("n_busy", busy, 1);
    chk("n_cpl_ready", s_cpl_ready, 0);
    tick;
    chk("n_req_cnt", rq_cnt, 1);
    send_resp(64'h1000, 8'd0, 6'd7, 1'b0, 1'b0);
    chk("n_wr_valid", wr_valid, 1);
    chk("n_wr_addr", wr_addr, 64'h1000);
    chk("n_wr_data", wr_data, da5);
    tick;
    chk("n_wr_cnt", wr_cnt, 1);
    chk("n_wr_valid_off", wr_valid, 0);
    tick; tick; tick;
    chk("n_no_early_commit", commit_valid, 0);
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    chk("n_commit_valid", commit_valid, 1);
    chk("n_commit_op", commit_op_tag, 7);
    tick;
    chk("n_commit_cnt", cm_cnt, 1);
    chk("n_idle", busy, 0);
    chk("n_cpl_ready_back", s_cpl_ready, 1);
    chk("n_drop", drop_count, 0);

    // stray write-done in IDLE
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    tick;
    chk("stray_done_busy", busy, 0);
    chk("stray_done_commit", cm_cnt, 1);

    // queue full
    send_cpl(5'd5, 128'h1234);
    chk("f_req_tag", req_tag, 1);
    tick;
    send_resp(64'h2000, 8'd1, 6'd3, 1'b1, 1'b0);
    chk("f_busy", busy, 0);
    chk("f_drop", drop_count, 1);
    chk("f_wr_valid", wr_valid, 0);
    tick;
    chk("f_wr_cnt", wr_cnt, 1);
    chk("f_commit_cnt", cm_cnt, 1);

    // full and error together count once
    send_cpl(5'd6, 128'h55);
    tick;
    send_resp(64'h2100, 8'd2, 6'd3, 1'b1, 1'b1);
    chk("fe_drop", drop_count, 2);

    // tag mismatch
    send_cpl(5'd7, 128'h66);
    chk("m_req_tag", req_tag, 3);
    tick;
    send_resp(64'h2200, 8'd4, 6'd3, 1'b0, 1'b0);
    chk("m_drop", drop_count, 3);
    chk("m_busy", busy, 0);
    chk("m_wr_valid", wr_valid, 0);

    // backpressure on request, write and commit
    req_ready = 1'b0;
    send_cpl(5'd9, 128'hBEEF);
    chk("bp_tag_advanced", req_tag, 4);
    b = rq_cnt;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_req_valid", req_valid, 1);
      chk("bp_req_queue", req_queue, 9);
      chk("bp_req_tag", req_tag, 4);
    end
    req_ready = 1'b1;
    tick;
    chk("bp_req_once", rq_cnt, b + 1);
    chk("bp_req_off", req_valid, 0);
    wr_ready = 1'b0;
    send_resp(64'h3000, 8'd4, 6'd12, 1'b0, 1'b0);
    b = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_wr_valid", wr_valid, 1);
      chk("bp_wr_addr", wr_addr, 64'h3000);
      chk("bp_wr_data", wr_data, 128'hBEEF);
    end
    wr_ready = 1'b1;
    tick;
    chk("bp_wr_once", wr_cnt, b + 1);
    chk("bp_wr_off", wr_valid, 0);
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    commit_ready = 1'b0;
    b = cm_cnt;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_cm_valid", commit_valid, 1);
      chk("bp_cm_op", commit_op_tag, 12);
    end
    commit_ready = 1'b1;
    tick;
    chk("bp_cm_once", cm_cnt, b + 1);
    chk("bp_cm_off", commit_valid, 0);
    tick;
    chk("bp_cm_no_dup", cm_cnt, b + 1);

    // reset while waiting for write-done
    send_cpl(5'd1, 128'hCAFE);
    tick;
    send_resp(64'h4000, 8'd5, 6'd9, 1'b0, 1'b0);
    tick;
    chk("r_busy_wait", busy, 1);
    b = cm_cnt;
    rst = 1'b1;
    #1;
    chk("r_busy", busy, 0);
    chk("r_cpl_ready", s_cpl_ready, 0);
    chk("r_req_valid", req_valid, 0);
    chk("r_resp_ready", resp_ready, 0);
    chk("r_wr_valid", wr_valid, 0);
    chk("r_cm_valid", commit_valid, 0);
    chk("r_drop", drop_count, 0);
    chk("r_wr_addr", wr_addr, 0);
    chk("r_wr_data", wr_data, 0);
    chk("r_req_tag", req_tag, 0);
    chk("r_req_queue", req_queue, 0);
    chk("r_cm_op", commit_op_tag, 0);
    tick;
    rst = 1'b0;
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    chk("r_late_done_cm", commit_valid, 0);
    chk("r_ready_back", s_cpl_ready, 1);
    tick;
    chk("r_no_commit", cm_cnt, b);
    send_cpl(5'd2, 128'hD00D);
    chk("r_new_tag", req_tag, 0);
    tick;
    send_resp(64'h5000, 8'd0, 6'd1, 1'b0, 1'b0);
    chk("r_new_wr_addr", wr_addr, 64'h5000);
    tick;
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    tick;
    chk("r_new_commit", cm_cnt, b + 1);
    chk("r_new_drop", drop_count, 0);

    // tag wrap: 256 refused completions, tags run 1..255 then 0
    for (int i = 0; i < 256; i++) begin
      send_cpl(i[4:0], 128'(i));
      et = 8'(i + 1);
      chk("wrap_tag", req_tag, et);
      tick;
      send_resp(64'h0, et, 6'd0, 1'b0, 1'b1);
    end
    chk("wrap_drop", drop_count, 256);
    send_cpl(5'd0, 128'h0);
    chk("wrap_next_tag", req_tag, 1);
    tick;
    send_resp(64'h0, 8'd1, 6'd0, 1'b1, 1'b0);
    chk("wrap_drop2", drop_count, 257);

    // saturation: preload just below the ceiling, then keep dropping
    force dut.drop_cnt = 16'hFFFD;
    tick;
    release dut.drop_cnt;
    chk("sat_preload", drop_count, 16'hFFFD);
    send_cpl(5'd0, 128'h0); tick;
    send_resp(64'h0, 8'd2, 6'd0, 1'b1, 1'b0);
    chk("sat_fffe", drop_count, 16'hFFFE);
    send_cpl(5'd0, 128'h0); tick;
    send_resp(64'h0, 8'd3, 6'd0, 1'b1, 1'b0);
    chk("sat_ffff", drop_count, 16'hFFFF);
    send_cpl(5'd0, 128'h0); tick;
    send_resp(64'h0, 8'd4, 6'd0, 1'b0, 1'b1);
    chk("sat_hold", drop_count, 16'hFFFF);
    chk("sat_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
